// File: rtl/comp_frame_parser_pkg.sv
// comp_frame_parser_pkg
// Shared types and constants for the compressed-frame parser.
//   - stream geometry (AXI_DATA_BITS / AXI_KEEP_BITS)
//   - page size and the width used for byte counts
//   - header field positions inside the 32-bit header word
//   - per-frame descriptor layout and the parser state enum
package comp_frame_parser_pkg;

  localparam int AXI_DATA_BITS   = 512;
  localparam int AXI_KEEP_BITS   = AXI_DATA_BITS / 8;
  localparam int PAGE_SIZE       = 4096;
  localparam int PAGE_SIZE_WIDTH = 16;

  // Header word: {uncom_size[31:16], com_size[15:0]}
  localparam int HDR_UNCOM_MSB = 31;
  localparam int HDR_UNCOM_LSB = 16;
  localparam int HDR_COM_MSB   = 15;
  localparam int HDR_COM_LSB   = 0;

  typedef enum logic {
    CFP_HEADER = 1'b0,
    CFP_BODY   = 1'b1
  } cfp_state_t;

  // err = {bad_header, len_mismatch, empty_body}
  typedef struct packed {
    logic [PAGE_SIZE_WIDTH-1:0] uncom;
    logic [PAGE_SIZE_WIDTH-1:0] com;
    logic [2:0]                 err;
  } comp_desc_t;

  // Number of valid bytes in a beat.
  function automatic logic [PAGE_SIZE_WIDTH-1:0] keep_bytes(
    input logic [AXI_KEEP_BITS-1:0] keep
  );
    logic [PAGE_SIZE_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < AXI_KEEP_BITS; i++) begin
      n = n + PAGE_SIZE_WIDTH'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/comp_frame_parser_fifo.sv
// comp_frame_parser_fifo
// Generic synchronous FIFO used to queue per-frame descriptors.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   i_push          write request, i_push_data payload
//   o_full          no free entry
//   i_pop           read acknowledge (head entry consumed)
//   o_valid         head entry present, o_pop_data is the head
module comp_frame_parser_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pop_data
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_valid    = (count_q != '0);
  assign o_pop_data = mem_q[rd_ptr_q];
  assign do_pop     = i_pop && o_valid;
  assign do_push    = i_push && (!o_full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q covers them.
  always_ff @(posedge aclk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/comp_frame_parser.sv
// comp_frame_parser
// Strips the 32-bit header {uncom_size, com_size} from each framed compressed
// stream, forwards the body unchanged (combinational, zero latency) and queues
// one descriptor {uncom, com, err} per frame.
// Build option: define COMP_FRAME_CHECK_EN to enable bad_header and
// len_mismatch detection; without it err[2:1] are constant 0.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   i_data_*               framed input stream (AXI4-Stream slave)
//   o_data_*               body-only output stream (AXI4-Stream master)
//   o_desc_valid/i_desc_ready, o_desc_uncom/com/err   descriptor sideband
//   o_frames               completed body frames, wraps at 2^32
module comp_frame_parser
  import comp_frame_parser_pkg::*;
#(
  parameter int DESC_DEPTH = 4,
  parameter int MAX_UNCOM  = PAGE_SIZE
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXI_DATA_BITS-1:0]   i_data_tdata,
  input  logic [AXI_KEEP_BITS-1:0]   i_data_tkeep,
  input  logic                       i_data_tlast,
  input  logic                       i_data_tvalid,
  output logic                       i_data_tready,
  output logic [AXI_DATA_BITS-1:0]   o_data_tdata,
  output logic [AXI_KEEP_BITS-1:0]   o_data_tkeep,
  output logic                       o_data_tlast,
  output logic                       o_data_tvalid,
  input  logic                       o_data_tready,
  output logic                       o_desc_valid,
  input  logic                       i_desc_ready,
  output logic [PAGE_SIZE_WIDTH-1:0] o_desc_uncom,
  output logic [PAGE_SIZE_WIDTH-1:0] o_desc_com,
  output logic [2:0]                 o_desc_err,
  output logic [31:0]                o_frames
);

`ifdef COMP_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  cfp_state_t                 state_q, state_d;
  logic [PAGE_SIZE_WIDTH-1:0] uncom_q, uncom_d;
  logic [PAGE_SIZE_WIDTH-1:0] com_size_q, com_size_d;
  logic [PAGE_SIZE_WIDTH-1:0] cnt_q, cnt_d;
  logic                       bad_hdr_q, bad_hdr_d;
  logic [31:0]                frames_q, frames_d;

  logic                       fifo_full;
  logic                       fifo_push;
  comp_desc_t                 push_desc;
  comp_desc_t                 head_desc;

  logic                       in_ready;
  logic                       out_valid;
  logic                       in_hs;

  logic [15:0]                hdr_uncom_raw;
  logic [PAGE_SIZE_WIDTH-1:0] hdr_uncom;
  logic [PAGE_SIZE_WIDTH-1:0] hdr_com;
  logic                       hdr_bad;

  logic [PAGE_SIZE_WIDTH-1:0] beat_bytes;
  logic [PAGE_SIZE_WIDTH:0]   cnt_sum;
  logic                       cnt_sat;
  logic [PAGE_SIZE_WIDTH-1:0] cnt_next;

  assign hdr_uncom_raw = i_data_tdata[HDR_UNCOM_MSB:HDR_UNCOM_LSB];
  assign hdr_uncom     = PAGE_SIZE_WIDTH'(hdr_uncom_raw);
  assign hdr_com       = PAGE_SIZE_WIDTH'(i_data_tdata[HDR_COM_MSB:HDR_COM_LSB]);
  assign hdr_bad       = (i_data_tkeep[3:0] != 4'hF)
                      || (hdr_uncom_raw == 16'd0)
                      || (32'(hdr_uncom_raw) > 32'(MAX_UNCOM));

  // One extra bit catches the carry; reaching all-ones is treated as saturated
  // since the true count can no longer be distinguished from overflow.
  assign beat_bytes = keep_bytes(i_data_tkeep);
  assign cnt_sum    = {1'b0, cnt_q} + {1'b0, beat_bytes};
  assign cnt_sat    = (cnt_sum >= {1'b0, {PAGE_SIZE_WIDTH{1'b1}}});
  assign cnt_next   = cnt_sat ? {PAGE_SIZE_WIDTH{1'b1}} : cnt_sum[PAGE_SIZE_WIDTH-1:0];

  assign in_hs = i_data_tvalid && in_ready;

  always_comb begin
    state_d    = state_q;
    uncom_d    = uncom_q;
    com_size_d = com_size_q;
    cnt_d      = cnt_q;
    bad_hdr_d  = bad_hdr_q;
    frames_d   = frames_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    fifo_push  = 1'b0;
    push_desc  = '0;

    unique case (state_q)
      CFP_HEADER: begin
        in_ready = !fifo_full;
        if (in_hs) begin
          if (i_data_tlast) begin
            // Header-only frame: report it immediately, stay here.
            fifo_push       = 1'b1;
            push_desc.uncom = hdr_uncom;
            push_desc.com   = '0;
            push_desc.err   = {CHECK_EN & hdr_bad, 1'b0, 1'b1};
          end else begin
            uncom_d    = hdr_uncom;
            com_size_d = hdr_com;
            bad_hdr_d  = hdr_bad;
            cnt_d      = '0;
            state_d    = CFP_BODY;
          end
        end
      end

      CFP_BODY: begin
        // The last beat is held back (valid and ready) while no descriptor
        // slot is free, so the output never sees a beat the input keeps.
        out_valid = i_data_tvalid && !(i_data_tlast && fifo_full);
        in_ready  = o_data_tready && !(i_data_tlast && fifo_full);
        if (in_hs) begin
          cnt_d = cnt_next;
          if (i_data_tlast) begin
            fifo_push       = 1'b1;
            push_desc.uncom = uncom_q;
            push_desc.com   = cnt_next;
            push_desc.err   = {CHECK_EN & bad_hdr_q,
                               CHECK_EN & (cnt_sat | (cnt_next != com_size_q)),
                               1'b0};
            frames_d        = frames_q + 32'd1;
            state_d         = CFP_HEADER;
          end
        end
      end

      default: begin
        state_d = CFP_HEADER;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= CFP_HEADER;
      uncom_q    <= '0;
      com_size_q <= '0;
      cnt_q      <= '0;
      bad_hdr_q  <= 1'b0;
      frames_q   <= '0;
    end else begin
      state_q    <= state_d;
      uncom_q    <= uncom_d;
      com_size_q <= com_size_d;
      cnt_q      <= cnt_d;
      bad_hdr_q  <= bad_hdr_d;
      frames_q   <= frames_d;
    end
  end

  comp_frame_parser_fifo #(
    .WIDTH ($bits(comp_desc_t)),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_push      (fifo_push),
    .i_push_data (push_desc),
    .o_full      (fifo_full),
    .i_pop       (i_desc_ready),
    .o_valid     (o_desc_valid),
    .o_pop_data  (head_desc)
  );

  // Reset is synchronous, so handshake outputs are masked combinationally to
  // stay quiet for the whole time aresetn is low.
  assign i_data_tready = in_ready && aresetn;
  assign o_data_tvalid = out_valid && aresetn;
  assign o_data_tdata  = i_data_tdata;
  assign o_data_tkeep  = i_data_tkeep;
  assign o_data_tlast  = i_data_tlast;

  assign o_desc_uncom = head_desc.uncom;
  assign o_desc_com   = head_desc.com;
  assign o_desc_err   = head_desc.err;
  assign o_frames     = frames_q;

endmodule

// File: tb/tb_comp_frame_parser.sv
module tb_comp_frame_parser;

  localparam int DB         = 512;
  localparam int KB         = 64;
  localparam int DESC_DEPTH = 4;
  localparam int MAX_UNCOM  = 4096;
  localparam int TMO        = 300;
`ifdef COMP_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DB-1:0] data;
    logic [KB-1:0] keep;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [DB-1:0] i_data_tdata;
  logic [KB-1:0] i_data_tkeep;
  logic          i_data_tlast;
  logic          i_data_tvalid;
  logic          i_data_tready;
  logic [DB-1:0] o_data_tdata;
  logic [KB-1:0] o_data_tkeep;
  logic          o_data_tlast;
  logic          o_data_tvalid;
  logic          o_data_tready;
  logic          o_desc_valid;
  logic          i_desc_ready;
  logic [15:0]   o_desc_uncom;
  logic [15:0]   o_desc_com;
  logic [2:0]    o_desc_err;
  logic [31:0]   o_frames;

  comp_frame_parser #(.DESC_DEPTH(DESC_DEPTH), .MAX_UNCOM(MAX_UNCOM)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_data_tdata(i_data_tdata), .i_data_tkeep(i_data_tkeep),
    .i_data_tlast(i_data_tlast), .i_data_tvalid(i_data_tvalid),
    .i_data_tready(i_data_tready),
    .o_data_tdata(o_data_tdata), .o_data_tkeep(o_data_tkeep),
    .o_data_tlast(o_data_tlast), .o_data_tvalid(o_data_tvalid),
    .o_data_tready(o_data_tready),
    .o_desc_valid(o_desc_valid), .i_desc_ready(i_desc_ready),
    .o_desc_uncom(o_desc_uncom), .o_desc_com(o_desc_com),
    .o_desc_err(o_desc_err), .o_frames(o_frames)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;
  int exp_frames = 0;
  bit otr_rand = 0;
  bit dr_rand = 0;
  bit desc_hold = 0;
  bit gaps_en = 0;

  beat_t         exp_beats[$];
  logic [34:0]   exp_desc[$];
  logic [DB-1:0] body_data[$];
  logic [KB-1:0] body_keep[$];

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Output readiness, randomized or forced.
  initial begin
    o_data_tready = 1'b0;
    i_desc_ready  = 1'b0;
    forever begin
      @(posedge aclk); #1;
      o_data_tready = otr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_desc_ready  = desc_hold ? 1'b0 : (dr_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn === 1'b1) begin
        if (o_data_tvalid && o_data_tready) begin
          checks++;
          if (exp_beats.size() == 0) begin
            errors++;
            $display("FAIL out_beat unexpected beat keep %h last %0d, none required", o_data_tkeep, o_data_tlast);
          end else begin
            beat_t e;
            e = exp_beats.pop_front();
            if (o_data_tdata !== e.data || o_data_tkeep !== e.keep || o_data_tlast !== e.last) begin
              errors++;
              $display("FAIL out_beat actual %h/%h/%0d required %h/%h/%0d",
                       o_data_tdata, o_data_tkeep, o_data_tlast, e.data, e.keep, e.last);
            end
          end
        end
        if (o_desc_valid && i_desc_ready) begin
          checks++;
          if (exp_desc.size() == 0) begin
            errors++;
            $display("FAIL desc unexpected %h, none required", {o_desc_uncom, o_desc_com, o_desc_err});
          end else begin
            logic [34:0] d;
            d = exp_desc.pop_front();
            if ({o_desc_uncom, o_desc_com, o_desc_err} !== d) begin
              errors++;
              $display("FAIL desc actual uncom %0d com %0d err %b required uncom %0d com %0d err %b",
                       o_desc_uncom, o_desc_com, o_desc_err, d[34:19], d[18:3], d[2:0]);
            end
          end
        end
      end
    end
  end

  function automatic logic [DB-1:0] rand_data();
    logic [DB-1:0] d;
    for (int i = 0; i < DB / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [KB-1:0] rand_keep();
    logic [KB-1:0] k;
    int m;
    m = $urandom_range(0, 2);
    k = '0;
    if (m == 0) k = '1;
    else if (m == 1) begin
      int n;
      n = $urandom_range(1, KB);
      for (int i = 0; i < n; i++) k[i] = 1'b1;
    end else k = {$urandom(), $urandom()};
    return k;
  endfunction

  function automatic logic [KB-1:0] low_keep(input int n);
    logic [KB-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  task automatic send_beat(input logic [DB-1:0] d, input logic [KB-1:0] k, input logic l);
    int n;
    if (gaps_en) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge aclk); #1; end
    end
    i_data_tdata  = d;
    i_data_tkeep  = k;
    i_data_tlast  = l;
    i_data_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (i_data_tready) break;
      n++;
      if (n >= TMO) break;
    end
    checks++;
    if (n >= TMO) begin
      errors++;
      $display("FAIL beat_accept no handshake after %0d cycles, required within %0d", n, TMO);
    end else last_hs = cyc;
    @(posedge aclk); #1;
    i_data_tvalid = 1'b0;
  endtask

  // Reference model: expectations from the frame rules, then drive the frame.
  int hdr_hs = 0;
  task automatic run_frame(input logic [15:0] u, input logic [15:0] c, input logic [KB-1:0] hk);
    int total;
    int nb;
    logic bad, mm;
    logic [15:0] com;
    logic [DB-1:0] hd;
    bad = CHECK_EN && (hk[3:0] != 4'hF || u == 0 || int'(u) > MAX_UNCOM);
    nb = body_keep.size();
    total = 0;
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      total += $countones(body_keep[i]);
      b.data = body_data[i];
      b.keep = body_keep[i];
      b.last = (i == nb - 1);
      exp_beats.push_back(b);
    end
    if (nb == 0) begin
      exp_desc.push_back({u, 16'd0, bad, 1'b0, 1'b1});
    end else begin
      com = (total >= 65535) ? 16'hFFFF : 16'(total);
      mm  = CHECK_EN && (total >= 65535 || total != int'(c));
      exp_desc.push_back({u, com, bad, mm, 1'b0});
      exp_frames++;
    end
    hd = rand_data();
    hd[31:0] = {u, c};
    send_beat(hd, hk, nb == 0);
    hdr_hs = last_hs;
    for (int i = 0; i < nb; i++) send_beat(body_data[i], body_keep[i], i == nb - 1);
    body_data.delete();
    body_keep.delete();
  endtask

  task automatic add_beat(input logic [KB-1:0] k);
    body_data.push_back(rand_data());
    body_keep.push_back(k);
  endtask

  task automatic drain();
    int n;
    desc_hold = 0;
    n = 0;
    while ((exp_beats.size() != 0 || exp_desc.size() != 0) && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain pending beats %0d descs %0d, required 0", exp_beats.size(), exp_desc.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    i_data_tvalid = 1'b1;
    i_data_tlast  = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_in_tready", 64'(i_data_tready), 64'd0);
    chk("rst_out_tvalid", 64'(o_data_tvalid), 64'd0);
    chk("rst_desc_valid", 64'(o_desc_valid), 64'd0);
    @(posedge aclk); #1;
    i_data_tvalid = 1'b0;
    aresetn = 1'b1;
    exp_frames = 0;
  endtask

  initial begin
    int t1;
    i_data_tdata = '0; i_data_tkeep = '0; i_data_tlast = 0; i_data_tvalid = 0;
    do_reset();
    chk("rst_frames", 64'(o_frames), 64'd0);

    // One 64-byte beat; descriptor visible right after the last handshake.
    add_beat('1);
    run_frame(16'h1000, 16'h0040, 64'hF);
    chk("desc_valid_next_cycle", 64'(o_desc_valid), 64'd1);
    t1 = last_hs;
    // Next header back-to-back: 64 + 16 bytes.
    add_beat('1);
    add_beat(low_keep(16));
    run_frame(16'h1000, 16'h0050, 64'hF);
    chk("no_bubble_hdr_cycle", 64'(hdr_hs), 64'(t1 + 1));
    drain();
    chk("frames_after_two", 64'(o_frames), 64'(exp_frames));

    // Length mismatch: 96 bytes against com=64.
    add_beat('1);
    add_beat(low_keep(32));
    run_frame(16'h1000, 16'h0040, 64'hF);
    // Header-only frame and a bad-header frame.
    run_frame(16'h1000, 16'h0000, 64'hF);
    add_beat('1);
    run_frame(16'h0000, 16'h0040, 64'h7);
    drain();

    // Randomized traffic with backpressure and gaps.
    otr_rand = 1; dr_rand = 1; gaps_en = 1;
    for (int f = 0; f < 40; f++) begin
      int nb, tot;
      logic [15:0] u, c;
      logic [KB-1:0] hk;
      nb = $urandom_range(0, 4);
      tot = 0;
      for (int b = 0; b < nb; b++) begin
        logic [KB-1:0] k;
        k = rand_keep();
        tot += $countones(k);
        add_beat(k);
      end
      case ($urandom_range(0, 4))
        0:       u = 16'd0;
        1:       u = 16'($urandom_range(MAX_UNCOM + 1, 65535));
        default: u = 16'($urandom_range(1, MAX_UNCOM));
      endcase
      c = ($urandom_range(0, 1) == 1) ? 16'(tot) : 16'($urandom());
      hk = ($urandom_range(0, 5) == 0) ? 64'(4'($urandom_range(0, 14))) :
           (($urandom_range(0, 1) == 1) ? 64'hF : '1);
      run_frame(u, c, hk);
    end
    drain();
    chk("frames_after_random", 64'(o_frames), 64'(exp_frames));

    // Counter saturation: 1030 full beats exceed the 16-bit count.
    otr_rand = 0; dr_rand = 0; gaps_en = 0;
    for (int b = 0; b < 1030; b++) add_beat('1);
    run_frame(16'h1000, 16'h0000, 64'hF);
    drain();

    // Descriptor FIFO full: DESC_DEPTH header-only frames, the next one stalls.
    desc_hold = 1;
    repeat (2) @(posedge aclk);
    #1;
    for (int f = 0; f < DESC_DEPTH; f++) run_frame(16'(100 + f), 16'd0, 64'hF);
    i_data_tdata  = '0;
    i_data_tdata[31:0] = {16'd200, 16'd0};
    i_data_tkeep  = 64'hF;
    i_data_tlast  = 1'b1;
    i_data_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("stall_tready", 64'(i_data_tready), 64'd0);
      chk("stall_desc_valid", 64'(o_desc_valid), 64'd1);
    end
    @(posedge aclk); #1;
    desc_hold = 0;
    run_frame(16'd200, 16'd0, 64'hF);
    drain();

    // Reset in the middle of a body, then a clean frame.
    begin
      logic [DB-1:0] hd;
      beat_t b;
      hd = rand_data();
      hd[31:0] = 32'h1000_0080;
      send_beat(hd, 64'hF, 1'b0);
      for (int i = 0; i < 2; i++) begin
        b.data = rand_data(); b.keep = '1; b.last = 1'b0;
        exp_beats.push_back(b);
        send_beat(b.data, b.keep, 1'b0);
      end
    end
    drain();
    do_reset();
    add_beat('1);
    run_frame(16'h0800, 16'h0040, 64'hF);
    drain();
    chk("frames_after_reset", 64'(o_frames), 64'd1);
    chk("idle_desc_valid", 64'(o_desc_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_frame_parser.md
# comp_frame_parser

Downstream stage of the compression arbiter. Consumes the framed compressed stream: one 32-bit header beat {uncom_size[31:16], com_size[15:0]} followed by body beats ending in tlast. Strips the header and forwards the body unchanged on an AXI4S master. Emits one per-frame descriptor (uncompressed size, compressed size, error flags) on a valid/ready sideband for the page writer / DMA descriptor logic.

## Interface
Parameters:
- DESC_DEPTH, 4: depth of the descriptor FIFO, in entries. Power of two, ≥2.
- MAX_UNCOM, PAGE_SIZE: largest legal uncom_size, in bytes.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset: synchronous, active-low.
- i_data  AXI4S.s  AXI_DATA_BITS  framed compressed stream (header beat, then body).
- o_data  AXI4S.m  AXI_DATA_BITS  body-only stream; tlast is copied from the input.
- o_desc_valid  out  1  descriptor available.
- i_desc_ready  in  1  descriptor consumer ready.
- o_desc_uncom  out  PAGE_SIZE_WIDTH  uncom_size from the header, zero-extended.
- o_desc_com  out  PAGE_SIZE_WIDTH  compressed byte count.
- o_desc_err  out  3  error flags: {bad_header, len_mismatch, empty_body}.
- o_frames  out  32  count of completed frames; wraps modulo 2^32.

## Operation
- FSM states: HEADER, BODY.
- Reset/idle state is HEADER.
- HEADER:
  - i_data.tready = 1 whenever the descriptor FIFO is not full.
  - On a header handshake: latch uncom_size and com_size, clear the byte counter, go to BODY.
  - Nothing is driven on o_data for the header beat.
- Empty frame: header beat with tlast=1.
  - Push a descriptor {uncom, com_count=0, empty_body=1}.
  - Stay in HEADER.
- BODY:
  - o_data.tdata/tkeep/tlast/tvalid = i_data equivalents.
  - i_data.tready = o_data.tready, gated low on the tlast beat if the descriptor FIFO is full.
  - Each handshake adds $countones(tkeep) to the byte counter (PAGE_SIZE_WIDTH bits, saturating at all-ones).
  - On the tlast handshake: push a descriptor with o_desc_com = counter + countones of this beat, increment o_frames, go to HEADER.
- bad_header is set when either holds:
  - header tkeep ≠ 4'hF in the low nibble;
  - uncom_size = 0 or uncom_size > MAX_UNCOM.
- A bad header is still consumed and its body is still forwarded; the flag only marks the frame.
- A frame with bad_header or len_mismatch set is reported and not dropped.
- Descriptor FIFO:
  - Push happens only on a frame end. A push and a pop in the same cycle are both allowed when the FIFO is full.
  - Descriptor order matches frame order.

## Timing
- Body path is combinational: zero latency, no register stage.
- Header beat costs 1 cycle with no output.
- Descriptor becomes visible (o_desc_valid=1) the cycle after the last-beat handshake.
- Back-to-back frames: the next header may be accepted the cycle after the body tlast, with no bubble.
- Reset values: state=HEADER, counter=0, o_frames=0, FIFO empty, o_desc_valid=0, o_data.tvalid=0, i_data.tready=0 during reset.
- Reset mid-frame: the partial frame is discarded with no descriptor. The first beat after reset is treated as a header.
- Counter saturation: reaching all-ones forces len_mismatch on that frame.

## Configuration
- `COMP_FRAME_CHECK_EN` defined:
  - The counter is compared with the header com_size at tlast; any difference sets len_mismatch.
  - bad_header checks are active.
- `COMP_FRAME_CHECK_EN` not defined:
  - o_desc_err[2:1] tie to 0; empty_body still works.
  - The comparison logic is removed; o_desc_com still reports the counted bytes.

## Structure
- Shared package common holds:
  - typedef comp_desc_t {uncom, com, err} (packed struct);
  - HDR_UNCOM_MSB/LSB and HDR_COM_MSB/LSB constants;
  - the header state enum cfp_state_t.
- Sub-module: the existing generic FIFO (WIDTH = $bits(comp_desc_t), DEPTH = DESC_DEPTH) for descriptors. Byte counting and the FSM live in this module.

## Test plan
- Header 0x1000_0040, one full 64-byte beat with tlast → o_data gets 1 beat; descriptor {4096, 64, 3'b000}; o_frames=1.
- Header 0x1000_0050, beats with keep of 64 bytes then 16 bytes (tlast) → descriptor {4096, 80, 000}; no output cycle for the header.
- With check enabled: header com=0x0040, body totalling 96 bytes → err=3'b010; body fully forwarded.
- Header with tlast=1 → no o_data beats; descriptor err=3'b001, com=0.
- Hold i_desc_ready=0 and send DESC_DEPTH+1 one-beat frames:
  - the last frame's tlast beat stalls (i_data.tready=0);
  - releasing ready drains the FIFO in order.
- aresetn pulsed low mid-body, then a new frame 0x0800_0040 + 64 B → exactly one descriptor {2048, 64, 000}; o_frames=1.
